// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the multiply/divide unit.
package mips_pkg;

  localparam int unsigned MdDataWidth = 32;

  typedef enum logic [2:0] {
    MdMult  = 3'b000,
    MdMultu = 3'b001,
    MdDiv   = 3'b010,
    MdDivu  = 3'b011,
    MdMthi  = 3'b100,
    MdMtlo  = 3'b101
  } md_op_t;

  // MULT/MULTU/DIV/DIVU all sit in the lower half of the encoding.
  function automatic logic md_is_arith(input logic [2:0] op);
    return op[2] == 1'b0;
  endfunction

endpackage

// File: rtl/md_step.sv
// One radix-2 iteration: shift-add multiply or restoring-divide step on the working registers.
module md_step
  import mips_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MdDataWidth
) (
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] acc,
  input  logic [DATA_WIDTH-1:0] wq,
  input  logic [DATA_WIDTH-1:0] opnd,
  output logic [DATA_WIDTH-1:0] acc_next,
  output logic [DATA_WIDTH-1:0] wq_next
);

  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] rem_sh;
  logic [DATA_WIDTH:0] diff;

  always_comb begin
    sum    = {1'b0, acc} + (wq[0] ? {1'b0, opnd} : '0);
    rem_sh = {acc, wq[DATA_WIDTH-1]};
    diff   = rem_sh - {1'b0, opnd};
    if (is_div) begin
      // Top bit of diff set means the trial subtraction borrowed: restore.
      if (diff[DATA_WIDTH]) begin
        acc_next = rem_sh[DATA_WIDTH-1:0];
        wq_next  = {wq[DATA_WIDTH-2:0], 1'b0};
      end else begin
        acc_next = diff[DATA_WIDTH-1:0];
        wq_next  = {wq[DATA_WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_next = sum[DATA_WIDTH:1];
      wq_next  = {sum[0], wq[DATA_WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Operates on operand magnitudes and applies the sign correction in a final FIX cycle.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MdDataWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_t;

  state_t                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d, wq_q, wq_d, opnd_q, opnd_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic                  is_div_q, is_div_d, neg_q, neg_d, neg_rem_q, neg_rem_d;
  logic                  dz_q, dz_d, done_q, done_d;

  logic [DATA_WIDTH-1:0]   acc_step, wq_step, mag_a, mag_b;
  logic [2*DATA_WIDTH-1:0] prod;
  logic                    sign_a, sign_b;
  md_op_t                  op_e;

  md_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_md_step (
    .is_div   (is_div_q),
    .acc      (acc_q),
    .wq       (wq_q),
    .opnd     (opnd_q),
    .acc_next (acc_step),
    .wq_next  (wq_step)
  );

  always_comb begin
    op_e   = md_op_t'(op);
    sign_a = ~op[0] & rs_data[DATA_WIDTH-1];
    sign_b = ~op[0] & rt_data[DATA_WIDTH-1];
    mag_a  = sign_a ? -rs_data : rs_data;
    mag_b  = sign_b ? -rt_data : rt_data;
    prod   = {acc_q, wq_q};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    wq_d      = wq_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          if (md_is_arith(op)) begin
            acc_d     = '0;
            wq_d      = mag_a;
            opnd_d    = mag_b;
            is_div_d  = op[1];
            neg_d     = sign_a ^ sign_b;
            neg_rem_d = sign_a;
            dz_d      = (rt_data == '0);
            cnt_d     = '0;
            state_d   = StCalc;
          end else if (op_e == MdMthi) begin
            hi_d = rs_data;
          end else if (op_e == MdMtlo) begin
            lo_d = rs_data;
          end
        end
      end
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d = acc_step;
          wq_d  = wq_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
            state_d = StFix;
          end
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            // Divide by zero leaves the all-ones quotient; remainder is the dividend restored
            // to its own sign, so hi ends up equal to rs_data.
            lo_d = dz_q ? '1 : (neg_q ? -wq_q : wq_q);
            hi_d = neg_rem_q ? -acc_q : acc_q;
          end else begin
            {hi_d, lo_d} = neg_q ? -prod : prod;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      wq_q      <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      wq_q      <= wq_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: transaction-level timeline model checked every cycle, plus directed vectors.
module tb_mult_div_unit;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    op = 3'd0;
  logic          flush = 1'b0;
  logic [DW-1:0] rs = '0;
  logic [DW-1:0] rt = '0;
  logic          busy, done;
  logic [DW-1:0] hi, lo;

  int errors = 0;
  int checks = 0;

  mult_div_unit #(
    .DATA_WIDTH(DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .flush   (flush),
    .rs_data (rs),
    .rt_data (rt),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  // Architectural result of one op, returned as {hi, lo}.
  function automatic logic [63:0] model_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              sa, sb;
    sa = a;
    sb = b;
    case (o)
      3'd0: begin
        sp = longint'(sa) * longint'(sb);
        return sp;
      end
      3'd1: begin
        up = {32'd0, a} * {32'd0, b};
        return up;
      end
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Timeline model: an accepted op at edge N retires at edge N+DW+1 unless flushed or reset.
  bit            pend = 1'b0;
  int            pend_edge = 0;
  logic [63:0]   pend_res = '0;
  logic [DW-1:0] m_hi = '0, m_lo = '0;
  logic          m_done = 1'b0;
  int            cyc = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      pend   = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
      m_done = 1'b0;
    end else begin
      cyc++;
      m_done = 1'b0;
      if (pend) begin
        if (flush) begin
          pend = 1'b0;
        end else if (cyc == pend_edge + DW + 1) begin
          {m_hi, m_lo} = pend_res;
          m_done = 1'b1;
          pend = 1'b0;
        end
      end else if (start && !flush) begin
        if (op < 3'd4) begin
          pend      = 1'b1;
          pend_edge = cyc;
          pend_res  = model_result(op, rs, rt);
        end else if (op == 3'd4) begin
          m_hi = rs;
        end else if (op == 3'd5) begin
          m_lo = rs;
        end
      end
    end
  end

  int printed = 0;
  initial forever begin
    @(negedge clk);
    checks++;
    if (busy !== pend || done !== m_done || hi !== m_hi || lo !== m_lo) begin
      errors++;
      if (printed < 20) begin
        printed++;
        $display("FAIL cycle_cmp t=%0t: got busy=%b done=%b hi=%h lo=%h, expected busy=%b done=%b hi=%h lo=%h",
                 $time, busy, done, hi, lo, pend, m_done, m_hi, m_lo);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit now);
    if (!now) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    op    = o;
    rs    = a;
    rt    = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    rs    = $urandom;
    rt    = $urandom;
  endtask

  // Cycles after the issue cycle until done is seen; -1 if the budget runs out.
  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  logic [31:0] corners [7] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
                                32'h7, 32'h2};

  initial begin
    int lat;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] a, b;

    // Pin the model with hand-computed results.
    check("model_mult", model_result(3'd0, 32'hFFFF_FFFF, 32'h2), 64'hFFFF_FFFF_FFFF_FFFE);
    check("model_multu", model_result(3'd1, 32'hFFFF_FFFF, 32'h2), 64'h0000_0001_FFFF_FFFE);
    check("model_div_neg", model_result(3'd2, 32'hFFFF_FFF9, 32'h2), 64'hFFFF_FFFF_FFFF_FFFD);
    check("model_div_ovf", model_result(3'd2, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
    check("model_divu_dz", model_result(3'd3, 32'h7, 32'h0), 64'h0000_0007_FFFF_FFFF);
    check("model_div_dz", model_result(3'd2, 32'hFFFF_FFF9, 32'h0), 64'hFFFF_FFF9_FFFF_FFFF);

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_state", {30'd0, busy, done, hi, lo}, 64'd0);

    issue(3'd0, 32'hFFFF_FFFF, 32'h2, 1'b0);
    wait_done(60, lat);
    check("mult_latency", lat, 34);
    check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);

    issue(3'd1, 32'hFFFF_FFFF, 32'h2, 1'b0);
    wait_done(60, lat);
    check("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

    issue(3'd2, 32'hFFFF_FFF9, 32'h2, 1'b0);
    wait_done(60, lat);
    check("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done(60, lat);
    check("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

    issue(3'd3, 32'h7, 32'h0, 1'b0);
    wait_done(60, lat);
    check("divu_dz_latency", lat, 34);
    check("divu_dz_hilo", {hi, lo}, 64'h0000_0007_FFFF_FFFF);

    // MTHI then MTLO on consecutive cycles.
    @(posedge clk);
    #1 start = 1'b1; op = 3'd4; rs = 32'h1234;
    @(posedge clk);
    #1 op = 3'd5; rs = 32'h5678;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("mthi_mtlo_hilo", {hi, lo}, 64'h0000_1234_0000_5678);
    check("mthi_mtlo_busy", busy, 0);

    // Flush during CALC: no done, hi/lo untouched.
    issue(3'd0, 32'h3, 32'h5, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    wait_done(40, lat);
    check("flush_calc_nodone", lat, -1);
    check("flush_calc_hilo", {hi, lo}, 64'h0000_1234_0000_5678);

    // Flush on the FIX edge suppresses the write.
    issue(3'd1, 32'h10, 32'h10, 1'b0);
    repeat (32) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    wait_done(40, lat);
    check("flush_fix_nodone", lat, -1);
    check("flush_fix_hilo", {hi, lo}, 64'h0000_1234_0000_5678);

    // Flush together with MTHI drops the write.
    @(posedge clk);
    #1 start = 1'b1; flush = 1'b1; op = 3'd4; rs = 32'hDEAD;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_mthi_hi", hi, 32'h1234);

    // Reset mid-CALC clears everything before the next edge.
    issue(3'd0, 32'h9, 32'h9, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_op", {30'd0, busy, done, hi, lo}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Back-to-back issue in the done cycle.
    issue(3'd1, 32'h0001_0000, 32'h0001_0000, 1'b0);
    wait_done(60, lat);
    check("b2b_first_hilo", {hi, lo}, 64'h0000_0001_0000_0000);
    issue(3'd2, 32'hFFFF_FFF9, 32'h2, 1'b1);
    wait_done(60, lat);
    check("b2b_second_latency", lat, 34);
    check("b2b_second_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    // start while busy is ignored.
    issue(3'd3, 32'd100, 32'd7, 1'b0);
    repeat (3) @(posedge clk);
    #1 start = 1'b1; op = 3'd0; rs = 32'd5; rt = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(60, lat);
    check("busy_start_latency", lat, 30);
    check("busy_start_hilo", {hi, lo}, {32'd2, 32'd14});
    wait_done(40, lat);
    check("busy_start_not_queued", lat, -1);

    // Sweep across corner and random operands for all four arithmetic ops.
    for (int i = 0; i < 32; i++) begin
      a = (i < 16) ? corners[i % 7] : $urandom;
      b = (i % 3 == 0) ? corners[(i * 3) % 7] : $urandom;
      issue(3'(i % 4), a, b, 1'b0);
      wait_done(60, lat);
      check("sweep_latency", lat, 34);
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
